// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage
//   Execute stage of the 8-bit accumulator pipeline: the ALU plus the EX/MEM
//   register. Single-cycle ops register their result one edge after capture.
//   MUL runs an iterative shift-add engine for MUL_CYCLES edges. During that
//   time `stall` is high and the outputs carry a bubble.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_opcode/dest    decoded instruction from ID/EX
//   in_imm            immediate operand
//   in_reg_val        register operand
//   in_acc_val        accumulator operand
//   in_reg_write      register write enable from ID/EX
//   in_mem_write      memory write enable from ID/EX
//   in_flush          synchronous squash of this stage (aborts a running MUL)
//   out_*             EX/MEM register contents toward the MEM stage
//   out_zero/carry    flags; they update only on LDI..MUL
//   stall             registered busy indication while the multiplier runs
// -----------------------------------------------------------------------------
module ex_stage #(
  parameter int MUL_CYCLES = 8  // must equal the 8-bit data width
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] in_opcode,
  input  logic [4:0] in_dest,
  input  logic [7:0] in_imm,
  input  logic [7:0] in_reg_val,
  input  logic [7:0] in_acc_val,
  input  logic       in_reg_write,
  input  logic       in_mem_write,
  input  logic       in_flush,
  output logic [2:0] out_opcode,
  output logic [4:0] out_dest,
  output logic [7:0] out_result,
  output logic [7:0] out_store_data,
  output logic       out_reg_write,
  output logic       out_mem_write,
  output logic       out_zero,
  output logic       out_carry,
  output logic       stall
);

  localparam int CNT_W = $clog2(MUL_CYCLES + 1);

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDI = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_ST  = 3'd7;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [2:0]       opcode_q, opcode_d;
  logic [4:0]       dest_q, dest_d;
  logic [7:0]       result_q, result_d;
  logic [7:0]       store_data_q, store_data_d;
  logic             reg_write_q, reg_write_d;
  logic             mem_write_q, mem_write_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             stall_q, stall_d;
  // Multiplier engine: the multiplicand shifts left and the multiplier
  // shifts right, so the current multiplier bit is always bit 0.
  logic [15:0]      mcand_q, mcand_d;
  logic [7:0]       mplier_q, mplier_d;
  logic [15:0]      product_q, product_d;
  logic [CNT_W-1:0] count_q, count_d;
  // Control of the MUL instruction, restored on its completion edge.
  logic [4:0]       mul_dest_q, mul_dest_d;
  logic             mul_reg_write_q, mul_reg_write_d;
  logic             mul_mem_write_q, mul_mem_write_d;

  logic [8:0]       sum;
  logic [8:0]       diff;
  logic [15:0]      product_step;

  always_comb begin
    // NOTE: every _d starts as its _q, so each branch below only states what
    // changes and no path through the block can infer a latch.
    state_d         = state_q;
    opcode_d        = opcode_q;
    dest_d          = dest_q;
    result_d        = result_q;
    store_data_d    = store_data_q;
    reg_write_d     = reg_write_q;
    mem_write_d     = mem_write_q;
    zero_d          = zero_q;
    carry_d         = carry_q;
    stall_d         = stall_q;
    mcand_d         = mcand_q;
    mplier_d        = mplier_q;
    product_d       = product_q;
    count_d         = count_q;
    mul_dest_d      = mul_dest_q;
    mul_reg_write_d = mul_reg_write_q;
    mul_mem_write_d = mul_mem_write_q;

    sum          = {1'b0, in_acc_val} + {1'b0, in_reg_val};
    // Bit 8 of the 9-bit difference is the borrow (acc < reg).
    diff         = {1'b0, in_acc_val} - {1'b0, in_reg_val};
    product_step = product_q + (mplier_q[0] ? mcand_q : 16'd0);

    case (state_q)
      IDLE: begin
        if (in_flush) begin
          opcode_d    = OP_NOP;
          reg_write_d = 1'b0;
          mem_write_d = 1'b0;
        end else if (in_opcode == OP_MUL) begin
          mcand_d         = {8'd0, in_acc_val};
          mplier_d        = in_reg_val;
          product_d       = '0;
          count_d         = '0;
          mul_dest_d      = in_dest;
          mul_reg_write_d = in_reg_write;
          mul_mem_write_d = in_mem_write;
          opcode_d        = OP_NOP;
          reg_write_d     = 1'b0;
          mem_write_d     = 1'b0;
          stall_d         = 1'b1;
          state_d         = BUSY;
        end else begin
          opcode_d    = in_opcode;
          dest_d      = in_dest;
          reg_write_d = in_reg_write;
          mem_write_d = in_mem_write;
          case (in_opcode)
            OP_NOP: result_d = 8'd0;
            OP_LDI: begin
              result_d = in_imm;
              zero_d   = (in_imm == 8'd0);
              carry_d  = 1'b0;
            end
            OP_ADD: begin
              result_d = sum[7:0];
              zero_d   = (sum[7:0] == 8'd0);
              carry_d  = sum[8];
            end
            OP_SUB: begin
              result_d = diff[7:0];
              zero_d   = (diff[7:0] == 8'd0);
              carry_d  = diff[8];
            end
            OP_AND: begin
              result_d = in_acc_val & in_reg_val;
              zero_d   = ((in_acc_val & in_reg_val) == 8'd0);
              carry_d  = 1'b0;
            end
            OP_OR: begin
              result_d = in_acc_val | in_reg_val;
              zero_d   = ((in_acc_val | in_reg_val) == 8'd0);
              carry_d  = 1'b0;
            end
            OP_ST: begin
              result_d     = 8'd0;
              store_data_d = in_acc_val;
            end
            default: result_d = 8'd0;  // OP_MUL is handled above
          endcase
        end
      end

      BUSY: begin
        if (in_flush) begin
          // Abort: the partial product is discarded, flags are untouched.
          opcode_d    = OP_NOP;
          reg_write_d = 1'b0;
          mem_write_d = 1'b0;
          product_d   = '0;
          count_d     = '0;
          stall_d     = 1'b0;
          state_d     = IDLE;
        end else begin
          product_d = product_step;
          mcand_d   = mcand_q << 1;
          mplier_d  = mplier_q >> 1;
          count_d   = count_q + 1'b1;
          if (count_q == CNT_W'(MUL_CYCLES - 1)) begin
            opcode_d    = OP_MUL;
            dest_d      = mul_dest_q;
            reg_write_d = mul_reg_write_q;
            mem_write_d = mul_mem_write_q;
            result_d    = product_step[7:0];
            zero_d      = (product_step[7:0] == 8'd0);
            carry_d     = |product_step[15:8];
            stall_d     = 1'b0;
            state_d     = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: the multiplier datapath registers are reset along with the outputs,
  // so a reset in the middle of a multiply leaves no partial product behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      opcode_q        <= '0;
      dest_q          <= '0;
      result_q        <= '0;
      store_data_q    <= '0;
      reg_write_q     <= 1'b0;
      mem_write_q     <= 1'b0;
      zero_q          <= 1'b0;
      carry_q         <= 1'b0;
      stall_q         <= 1'b0;
      mcand_q         <= '0;
      mplier_q        <= '0;
      product_q       <= '0;
      count_q         <= '0;
      mul_dest_q      <= '0;
      mul_reg_write_q <= 1'b0;
      mul_mem_write_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the values from
      // before the edge, regardless of statement order.
      state_q         <= state_d;
      opcode_q        <= opcode_d;
      dest_q          <= dest_d;
      result_q        <= result_d;
      store_data_q    <= store_data_d;
      reg_write_q     <= reg_write_d;
      mem_write_q     <= mem_write_d;
      zero_q          <= zero_d;
      carry_q         <= carry_d;
      stall_q         <= stall_d;
      mcand_q         <= mcand_d;
      mplier_q        <= mplier_d;
      product_q       <= product_d;
      count_q         <= count_d;
      mul_dest_q      <= mul_dest_d;
      mul_reg_write_q <= mul_reg_write_d;
      mul_mem_write_q <= mul_mem_write_d;
    end
  end

  assign out_opcode     = opcode_q;
  assign out_dest       = dest_q;
  assign out_result     = result_q;
  assign out_store_data = store_data_q;
  assign out_reg_write  = reg_write_q;
  assign out_mem_write  = mem_write_q;
  assign out_zero       = zero_q;
  assign out_carry      = carry_q;
  assign stall          = stall_q;

endmodule

// File: tb/tb_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_ex_stage
//   Directed bench for ex_stage. The driver applies one instruction per cycle
//   at the falling edge and pushes the hand-computed state expected after the
//   following rising edge. A monitor pops one entry per cycle (1 time unit
//   after the rising edge) and compares every output, including stall.
// -----------------------------------------------------------------------------
module tb_ex_stage;

  localparam logic [2:0] NOP = 3'd0, LDI = 3'd1, ADD = 3'd2, SUB = 3'd3,
                         AND = 3'd4, OR  = 3'd5, MUL = 3'd6, ST  = 3'd7;

  logic       clk;
  logic       rst;
  logic [2:0] in_opcode;
  logic [4:0] in_dest;
  logic [7:0] in_imm;
  logic [7:0] in_reg_val;
  logic [7:0] in_acc_val;
  logic       in_reg_write;
  logic       in_mem_write;
  logic       in_flush;
  logic [2:0] out_opcode;
  logic [4:0] out_dest;
  logic [7:0] out_result;
  logic [7:0] out_store_data;
  logic       out_reg_write;
  logic       out_mem_write;
  logic       out_zero;
  logic       out_carry;
  logic       stall;

  ex_stage #(.MUL_CYCLES(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_opcode     (in_opcode),
    .in_dest       (in_dest),
    .in_imm        (in_imm),
    .in_reg_val    (in_reg_val),
    .in_acc_val    (in_acc_val),
    .in_reg_write  (in_reg_write),
    .in_mem_write  (in_mem_write),
    .in_flush      (in_flush),
    .out_opcode    (out_opcode),
    .out_dest      (out_dest),
    .out_result    (out_result),
    .out_store_data(out_store_data),
    .out_reg_write (out_reg_write),
    .out_mem_write (out_mem_write),
    .out_zero      (out_zero),
    .out_carry     (out_carry),
    .stall         (stall)
  );

  typedef struct packed {
    logic [2:0] opcode;
    logic [4:0] dest;
    logic [7:0] result;
    logic [7:0] store_data;
    logic       reg_write;
    logic       mem_write;
    logic       zero;
    logic       carry;
    logic       stall;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_vec    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic compare(input string tag, input exp_t e);
    check({tag, " opcode"},     16'(out_opcode),     16'(e.opcode));
    check({tag, " dest"},       16'(out_dest),       16'(e.dest));
    check({tag, " result"},     16'(out_result),     16'(e.result));
    check({tag, " store_data"}, 16'(out_store_data), 16'(e.store_data));
    check({tag, " reg_write"},  16'(out_reg_write),  16'(e.reg_write));
    check({tag, " mem_write"},  16'(out_mem_write),  16'(e.mem_write));
    check({tag, " zero"},       16'(out_zero),       16'(e.zero));
    check({tag, " carry"},      16'(out_carry),      16'(e.carry));
    check({tag, " stall"},      16'(stall),          16'(e.stall));
  endtask

  // Monitor: one expectation per clock cycle while the scoreboard has entries.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        compare($sformatf("v%0d", n_vec), e);
        n_vec++;
      end
    end
  end

  task automatic set_in(input logic [2:0] op, input logic [4:0] dest,
                        input logic [7:0] imm, input logic [7:0] rv,
                        input logic [7:0] av, input logic rw, input logic mw,
                        input logic fl);
    in_opcode    = op;
    in_dest      = dest;
    in_imm       = imm;
    in_reg_val   = rv;
    in_acc_val   = av;
    in_reg_write = rw;
    in_mem_write = mw;
    in_flush     = fl;
  endtask

  task automatic drive(input logic [2:0] op, input logic [4:0] dest,
                       input logic [7:0] imm, input logic [7:0] rv,
                       input logic [7:0] av, input logic rw, input logic mw,
                       input logic fl);
    @(negedge clk);
    set_in(op, dest, imm, rv, av, rw, mw, fl);
  endtask

  task automatic expect_out(input logic [2:0] op, input logic [4:0] dest,
                            input logic [7:0] res, input logic [7:0] sd,
                            input logic rw, input logic mw, input logic z,
                            input logic c, input logic stl);
    sb.push_back('{op, dest, res, sd, rw, mw, z, c, stl});
  endtask

  initial begin
    rst = 1'b1;
    set_in(NOP, 5'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    #2;
    compare("reset", '{3'd0, 5'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;

    // Single-cycle ALU stream.
    drive(LDI, 5'd1, 8'h80, 8'h00, 8'h00, 1, 0, 0); expect_out(LDI, 5'd1, 8'h80, 8'h00, 1, 0, 0, 0, 0);
    drive(ADD, 5'd2, 8'h00, 8'h80, 8'h80, 1, 0, 0); expect_out(ADD, 5'd2, 8'h00, 8'h00, 1, 0, 1, 1, 0);
    drive(SUB, 5'd3, 8'h00, 8'h05, 8'h03, 1, 0, 0); expect_out(SUB, 5'd3, 8'hFE, 8'h00, 1, 0, 0, 1, 0);
    drive(AND, 5'd4, 8'h00, 8'h0F, 8'hF0, 1, 0, 0); expect_out(AND, 5'd4, 8'h00, 8'h00, 1, 0, 1, 0, 0);
    drive(OR,  5'd6, 8'h00, 8'h30, 8'h0F, 1, 0, 0); expect_out(OR,  5'd6, 8'h3F, 8'h00, 1, 0, 0, 0, 0);
    // Flags hold across NOP and ST.
    drive(ADD, 5'd8, 8'h00, 8'h01, 8'hFF, 1, 0, 0); expect_out(ADD, 5'd8, 8'h00, 8'h00, 1, 0, 1, 1, 0);
    drive(NOP, 5'd9, 8'h77, 8'h12, 8'h34, 0, 0, 0); expect_out(NOP, 5'd9, 8'h00, 8'h00, 0, 0, 1, 1, 0);
    drive(ST,  5'd7, 8'h00, 8'h00, 8'h5A, 0, 1, 0); expect_out(ST,  5'd7, 8'h00, 8'h5A, 0, 1, 1, 1, 0);

    // MUL with overflow: 0x13 * 0x11 = 0x0143.
    drive(MUL, 5'd5, 8'h00, 8'h11, 8'h13, 1, 0, 0); expect_out(NOP, 5'd7, 8'h00, 8'h5A, 0, 0, 1, 1, 1);
    for (int i = 1; i < 8; i++) begin
      drive(MUL, 5'd5, 8'h00, 8'h11, 8'h13, 1, 0, 0); expect_out(NOP, 5'd7, 8'h00, 8'h5A, 0, 0, 1, 1, 1);
    end
    drive(MUL, 5'd5, 8'h00, 8'h11, 8'h13, 1, 0, 0); expect_out(MUL, 5'd5, 8'h43, 8'h5A, 1, 0, 0, 1, 0);

    // Edge values back-to-back: 0x00 * 0xFF, then 0xFF * 0xFF = 0xFE01.
    drive(MUL, 5'd10, 8'h00, 8'hFF, 8'h00, 1, 0, 0); expect_out(NOP, 5'd5, 8'h43, 8'h5A, 0, 0, 0, 1, 1);
    for (int i = 1; i < 8; i++) begin
      drive(MUL, 5'd10, 8'h00, 8'hFF, 8'h00, 1, 0, 0); expect_out(NOP, 5'd5, 8'h43, 8'h5A, 0, 0, 0, 1, 1);
    end
    drive(MUL, 5'd10, 8'h00, 8'hFF, 8'h00, 1, 0, 0); expect_out(MUL, 5'd10, 8'h00, 8'h5A, 1, 0, 1, 0, 0);
    drive(MUL, 5'd11, 8'h00, 8'hFF, 8'hFF, 1, 0, 0); expect_out(NOP, 5'd10, 8'h00, 8'h5A, 0, 0, 1, 0, 1);
    for (int i = 1; i < 8; i++) begin
      drive(MUL, 5'd11, 8'h00, 8'hFF, 8'hFF, 1, 0, 0); expect_out(NOP, 5'd10, 8'h00, 8'h5A, 0, 0, 1, 0, 1);
    end
    drive(MUL, 5'd11, 8'h00, 8'hFF, 8'hFF, 1, 0, 0); expect_out(MUL, 5'd11, 8'h01, 8'h5A, 1, 0, 0, 1, 0);

    // Stall hold: ADD 2+3 waits at the inputs during MUL 5*3.
    drive(MUL, 5'd12, 8'h00, 8'h03, 8'h05, 1, 0, 0); expect_out(NOP, 5'd11, 8'h01, 8'h5A, 0, 0, 0, 1, 1);
    for (int i = 1; i < 8; i++) begin
      drive(ADD, 5'd13, 8'h00, 8'h03, 8'h02, 1, 0, 0); expect_out(NOP, 5'd11, 8'h01, 8'h5A, 0, 0, 0, 1, 1);
    end
    drive(ADD, 5'd13, 8'h00, 8'h03, 8'h02, 1, 0, 0); expect_out(MUL, 5'd12, 8'h0F, 8'h5A, 1, 0, 0, 0, 0);
    drive(ADD, 5'd13, 8'h00, 8'h03, 8'h02, 1, 0, 0); expect_out(ADD, 5'd13, 8'h05, 8'h5A, 1, 0, 0, 0, 0);

    // Flush at E3 of a MUL, then ST; flags (z1 c1) must survive.
    drive(ADD, 5'd16, 8'h00, 8'h01, 8'hFF, 1, 0, 0); expect_out(ADD, 5'd16, 8'h00, 8'h5A, 1, 0, 1, 1, 0);
    drive(MUL, 5'd14, 8'h00, 8'h33, 8'h22, 1, 0, 0); expect_out(NOP, 5'd16, 8'h00, 8'h5A, 0, 0, 1, 1, 1);
    for (int i = 1; i < 3; i++) begin
      drive(MUL, 5'd14, 8'h00, 8'h33, 8'h22, 1, 0, 0); expect_out(NOP, 5'd16, 8'h00, 8'h5A, 0, 0, 1, 1, 1);
    end
    drive(MUL, 5'd14, 8'h00, 8'h33, 8'h22, 1, 0, 1); expect_out(NOP, 5'd16, 8'h00, 8'h5A, 0, 0, 1, 1, 0);
    drive(ST,  5'd15, 8'h00, 8'h00, 8'hAA, 0, 1, 0); expect_out(ST,  5'd15, 8'h00, 8'hAA, 0, 1, 1, 1, 0);

    // Flush on the completion edge E8 suppresses the MUL result.
    drive(MUL, 5'd17, 8'h00, 8'h02, 8'h02, 1, 0, 0); expect_out(NOP, 5'd15, 8'h00, 8'hAA, 0, 0, 1, 1, 1);
    for (int i = 1; i < 8; i++) begin
      drive(MUL, 5'd17, 8'h00, 8'h02, 8'h02, 1, 0, 0); expect_out(NOP, 5'd15, 8'h00, 8'hAA, 0, 0, 1, 1, 1);
    end
    drive(MUL, 5'd17, 8'h00, 8'h02, 8'h02, 1, 0, 1); expect_out(NOP, 5'd15, 8'h00, 8'hAA, 0, 0, 1, 1, 0);
    drive(NOP, 5'd0,  8'h00, 8'h00, 8'h00, 0, 0, 0); expect_out(NOP, 5'd0,  8'h00, 8'hAA, 0, 0, 1, 1, 0);

    // Flush overrides a MUL capture and a plain ALU capture in IDLE.
    drive(MUL, 5'd18, 8'h00, 8'h04, 8'h04, 1, 0, 1); expect_out(NOP, 5'd0,  8'h00, 8'hAA, 0, 0, 1, 1, 0);
    drive(LDI, 5'd19, 8'h00, 8'h00, 8'h00, 1, 0, 0); expect_out(LDI, 5'd19, 8'h00, 8'hAA, 1, 0, 1, 0, 0);
    drive(ADD, 5'd20, 8'h00, 8'h01, 8'h01, 1, 0, 1); expect_out(NOP, 5'd19, 8'h00, 8'hAA, 0, 0, 1, 0, 0);

    // Reset asserted before E4 of a MUL and held across E4.
    drive(MUL, 5'd21, 8'h00, 8'h11, 8'h13, 1, 0, 0); expect_out(NOP, 5'd19, 8'h00, 8'hAA, 0, 0, 1, 0, 1);
    for (int i = 1; i < 4; i++) begin
      drive(MUL, 5'd21, 8'h00, 8'h11, 8'h13, 1, 0, 0); expect_out(NOP, 5'd19, 8'h00, 8'hAA, 0, 0, 1, 0, 1);
    end
    @(negedge clk);
    rst = 1'b1;
    set_in(NOP, 5'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    #1;
    compare("midmul_reset", '{3'd0, 5'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    set_in(ADD, 5'd3, 8'h00, 8'h01, 8'h01, 1, 0, 0); expect_out(ADD, 5'd3, 8'h02, 8'h00, 1, 0, 0, 0, 0);
    drive(NOP, 5'd0, 8'h00, 8'h00, 8'h00, 0, 0, 0);  expect_out(NOP, 5'd0, 8'h00, 8'h00, 0, 0, 0, 0, 0);

    // Drain: the monitor consumes one entry per cycle.
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
